// File: rtl/sram_pkg.sv
// Shared types and helpers for the sram_dff_v2 memory and its clear sequencer.
package sram_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic {S_CLEAR, S_IDLE} sram_state_t;

  function automatic logic byte_parity(logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/sram_clear_seq.sv
// Post-reset clear sequencer: walks clr_add over every word once and raises busy meanwhile.
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int CLEAR_ON_RESET = 1,
  parameter int AW             = 3
) (
  input  logic          clk,
  input  logic          reset,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_add
);
  localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
  localparam sram_state_t   RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  sram_state_t   state, state_nxt;
  logic [AW-1:0] clr_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RST_STATE;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_CLEAR) clr_cnt <= (clr_cnt == LAST) ? '0 : clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && clr_cnt == LAST) state_nxt = S_IDLE;
  end

  // busy reflects the reset target while reset is held so it is defined from the first cycle.
  always_comb begin
    busy    = reset ? (CLEAR_ON_RESET != 0) : (state == S_CLEAR);
    clr_we  = !reset && (state == S_CLEAR);
    clr_add = clr_cnt;
  end
endmodule

// File: rtl/sram_dff_v2.sv
// Single-port flip-flop SRAM with byte enables, registered read and post-reset clear.
// Optional per-byte even parity when SRAM_PARITY_EN is defined.
module sram_dff_v2
  import sram_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 8,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    we,
  input  logic [AW-1:0]           add,
  input  logic [WIDTH/BYTE_W-1:0] be,
  input  logic [WIDTH-1:0]        wd,
  output logic [WIDTH-1:0]        rd,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    parity_err
);
  localparam int NB = WIDTH / BYTE_W;

  if (WIDTH % BYTE_W != 0 || WIDTH == 0) begin : g_width_chk
    $error("sram_dff_v2: WIDTH must be a nonzero multiple of 8");
  end

  logic          clr_we;
  logic [AW-1:0] clr_add;
  logic          in_range, wr_en, rd_en, par_bad;

  sram_clear_seq #(
    .DEPTH         (DEPTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET),
    .AW            (AW)
  ) u_clr (
    .clk    (clk),
    .reset  (reset),
    .busy   (busy),
    .clr_we (clr_we),
    .clr_add(clr_add)
  );

  // Only reachable when DEPTH is not a power of two.
  assign in_range = {1'b0, add} < (AW + 1)'(DEPTH);
  assign wr_en    = req && we && !busy && !reset && in_range;
  assign rd_en    = req && !we && !busy && !reset;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) mem[clr_add] <= '0;
    else if (wr_en)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[add][i*BYTE_W +: BYTE_W] <= wd[i*BYTE_W +: BYTE_W];
  end

`ifdef SRAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) par[clr_add] <= '0;
    else if (wr_en)
      for (int i = 0; i < NB; i++)
        if (be[i]) par[add][i] <= byte_parity(wd[i*BYTE_W +: BYTE_W]);
  end

  always_comb begin
    par_bad = 1'b0;
    for (int i = 0; i < NB; i++)
      par_bad = par_bad | (byte_parity(mem[add][i*BYTE_W +: BYTE_W]) != par[add][i]);
  end
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rd         <= '0;
      rd_valid   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rd_valid   <= rd_en;
      parity_err <= rd_en && in_range && par_bad;
      if (rd_en) rd <= in_range ? mem[add] : '0;
    end
  end
endmodule

// File: tb/tb_sram_dff_v2.sv
// Scoreboard bench for sram_dff_v2: a DEPTH=8 and a DEPTH=6 instance share clock, reset and data.
module tb_sram_dff_v2;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req8 = 1'b0, req6 = 1'b0, we = 1'b0;
  logic [2:0]  add = '0;
  logic [3:0]  be = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd8, rd6;
  logic        v8, v6, b8, b6, p8, p6;

  int checks = 0, failures = 0;
  logic [32:0] q8[$], q6[$];   // {expected rd, expected parity_err}

  always #5 clk = ~clk;

  sram_dff_v2 #(.WIDTH(32), .DEPTH(8), .CLEAR_ON_RESET(1)) dut8 (
    .clk(clk), .reset(reset), .req(req8), .we(we), .add(add), .be(be), .wd(wd),
    .rd(rd8), .rd_valid(v8), .busy(b8), .parity_err(p8));

  sram_dff_v2 #(.WIDTH(32), .DEPTH(6), .CLEAR_ON_RESET(1)) dut6 (
    .clk(clk), .reset(reset), .req(req6), .we(we), .add(add), .be(be), .wd(wd),
    .rd(rd6), .rd_valid(v6), .busy(b6), .parity_err(p6));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (v8) begin
      if (q8.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut8_unexpected_rd_valid actual rd=%h expected no read", rd8);
      end else begin
        logic [32:0] e8;
        e8 = q8.pop_front();
        chk("dut8_rd", rd8, e8[32:1]);
        chk("dut8_parity_err", 32'(p8), 32'(e8[0]));
      end
    end
    if (v6) begin
      if (q6.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut6_unexpected_rd_valid actual rd=%h expected no read", rd6);
      end else begin
        logic [32:0] e6;
        e6 = q6.pop_front();
        chk("dut6_rd", rd6, e6[32:1]);
        chk("dut6_parity_err", 32'(p6), 32'(e6[0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input bit sel6, input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
    we = 1'b1; add = a; wd = d; be = b;
    if (sel6) req6 = 1'b1; else req8 = 1'b1;
    tick();
    req8 = 1'b0; req6 = 1'b0;
  endtask

  task automatic rdq(input bit sel6, input logic [2:0] a, input logic [31:0] exp, input logic perr);
    we = 1'b0; add = a; be = 4'h0; wd = 32'hFFFF_FFFF;
    if (sel6) begin q6.push_back({exp, perr}); req6 = 1'b1; end
    else      begin q8.push_back({exp, perr}); req8 = 1'b1; end
    tick();
    req8 = 1'b0; req6 = 1'b0;
  endtask

  // Counts cycles with busy high; the 20-cycle bound turns a stuck busy into a count mismatch.
  task automatic count_busy(output int n8, output int n6);
    n8 = 0; n6 = 0;
    for (int i = 0; i < 20 && (b8 || b6); i++) begin
      if (b8) n8++;
      if (b6) n6++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n8, n6;
    reset = 1'b1;
    repeat (3) tick();
    chk("reset_rd", rd8, 32'h0);
    chk("reset_rd_valid", 32'(v8), 32'h0);
    chk("reset_parity_err", 32'(p8), 32'h0);
    chk("reset_busy8", 32'(b8), 32'h1);
    chk("reset_busy6", 32'(b6), 32'h1);
    reset = 1'b0;
    count_busy(n8, n6);
    chk("busy_len_depth8", n8, 32'd8);
    chk("busy_len_depth6", n6, 32'd6);

    for (int a = 0; a < 8; a++) rdq(1'b0, 3'(a), 32'h0, 1'b0);

    wr(1'b0, 3'd3, 32'hDEAD_BEEF, 4'hF);
    wr(1'b0, 3'd3, 32'h1122_3344, 4'b0101);
    rdq(1'b0, 3'd3, 32'hDE22_BE44, 1'b0);

    wr(1'b0, 3'd1, 32'hFFFF_FFFF, 4'h0);
    rdq(1'b0, 3'd1, 32'h0, 1'b0);

    // Write then two back-to-back reads of the same word.
    wr(1'b0, 3'd5, 32'hCAFE_F00D, 4'hF);
    we = 1'b0; add = 3'd5; req8 = 1'b1;
    q8.push_back({32'hCAFE_F00D, 1'b0});
    q8.push_back({32'hCAFE_F00D, 1'b0});
    tick();
    chk("b2b_valid_first", 32'(v8), 32'h1);
    tick();
    chk("b2b_valid_second", 32'(v8), 32'h1);
    req8 = 1'b0;
    tick();
    chk("idle_valid_low", 32'(v8), 32'h0);
    tick();
    chk("idle_rd_hold", rd8, 32'hCAFE_F00D);

    // Out-of-range access on the DEPTH=6 instance.
    wr(1'b1, 3'd5, 32'hA5A5_A5A5, 4'hF);
    wr(1'b1, 3'd7, 32'h0000_0005, 4'hF);
    rdq(1'b1, 3'd7, 32'h0, 1'b0);
    for (int a = 0; a < 5; a++) rdq(1'b1, 3'(a), 32'h0, 1'b0);
    rdq(1'b1, 3'd5, 32'hA5A5_A5A5, 1'b0);

    // Reset mid-clear restarts the sweep; writes during busy are dropped.
    wr(1'b0, 3'd0, 32'hAAAA_AAAA, 4'hF);
    wr(1'b0, 3'd7, 32'h7777_7777, 4'hF);
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (4) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    we = 1'b1; add = 3'd0; wd = 32'hFFFF_FFFF; be = 4'hF; req8 = 1'b1;
    count_busy(n8, n6);
    req8 = 1'b0;
    chk("restart_busy_len8", n8, 32'd8);
    chk("restart_busy_len6", n6, 32'd6);
    rdq(1'b0, 3'd0, 32'h0, 1'b0);
    rdq(1'b0, 3'd3, 32'h0, 1'b0);
    rdq(1'b0, 3'd7, 32'h0, 1'b0);

`ifdef SRAM_PARITY_EN
    wr(1'b0, 3'd2, 32'h0000_00FF, 4'hF);
    wr(1'b0, 3'd4, 32'h0000_00FF, 4'hF);
    @(negedge clk);
    dut8.mem[2][0] = ~dut8.mem[2][0];
    @(posedge clk); #1;
    rdq(1'b0, 3'd2, 32'h0000_00FE, 1'b1);
    rdq(1'b0, 3'd4, 32'h0000_00FF, 1'b0);
`endif

    repeat (3) tick();
    checks++;
    if (q8.size() != 0 || q6.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual pending=%0d expected pending=0", q8.size() + q6.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_dff_v2.md
Name: sram_dff_v2

Overview:
- Parametrised successor to the 8x32 flip-flop SRAM: configurable width and depth, per-byte write enables, and registered read data with a valid strobe.
- Adds a post-reset hardware clear sequencer and a busy flag.
- Single port: one read or write per cycle. Sits beside the flip-flop SRAM as the general-purpose small memory for register files and scratch buffers.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8 (elaboration error otherwise).
- DEPTH, 8, number of words; need not be a power of 2.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents untouched by reset.
- AW (localparam), $clog2(DEPTH) with a minimum of 1, address width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  1  operation request, sampled at rising clk.
- we  input  1  1 = write, 0 = read; qualified by req.
- add  input  AW  word address.
- be  input  WIDTH/8  byte write enables; be[i] covers wd[8i+7:8i].
- wd  input  WIDTH  write data.
- rd  output  WIDTH  registered read data.
- rd_valid  output  1  one-cycle pulse; rd holds a new read result.
- busy  output  1  clear sequence in progress; requests are ignored.
- parity_err  output  1  parity mismatch on the current read (see Optional Feature).

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset). All state changes on rising clk only.
- During reset: rd = 0, rd_valid = 0, parity_err = 0, clear counter = 0.
  - busy = 1 if CLEAR_ON_RESET = 1, else busy = 0.
  - Memory array itself is not reset.
- FSM states: S_CLEAR and S_IDLE.
  - reset forces S_CLEAR when CLEAR_ON_RESET = 1, else S_IDLE.
  - S_CLEAR: each cycle writes 0 (and matching parity) to word clr_cnt, then increments clr_cnt.
  - After the word at DEPTH-1 is written, go to S_IDLE. busy deasserts in the cycle after that edge, so busy is high for exactly DEPTH cycles after reset deasserts.
  - Reset asserted mid-clear restarts the clear from address 0.
- In S_CLEAR, req is ignored: no write happens and no rd_valid is produced.
- Write (S_IDLE, req = 1, we = 1, sampled at edge E):
  - Each lane with be[i] = 1 updates at E; other lanes hold.
  - be = 0 is a legal no-op.
  - rd and rd_valid are unaffected (rd_valid = 0 next cycle).
- Read (S_IDLE, req = 1, we = 0, sampled at edge E):
  - rd <= mem[add] and rd_valid <= 1 at E, so both are visible in the cycle after E. Latency is 1 cycle.
  - be and wd are ignored.
- Read after write to the same address on consecutive edges returns the newly written data.
- rd holds its last value when no read occurs. rd_valid is 0 in every cycle not following an accepted read.
- Out-of-range address (add >= DEPTH, only possible when DEPTH is not a power of 2):
  - Write is dropped.
  - Read returns rd = 0 with rd_valid = 1.
- req = 0: no state change; rd_valid <= 0.
- Back-to-back reads every cycle are supported: rd_valid stays high continuously.

Optional Feature:
- Macro: SRAM_PARITY_EN.
- Defined:
  - Each byte lane stores an extra even-parity bit, computed from the written byte on every write (clear writes parity 0).
  - On a read, parity is recomputed per lane. parity_err <= 1 alongside rd_valid if any lane mismatches, and is 0 otherwise.
  - Array width becomes WIDTH + WIDTH/8.
- Undefined: no parity storage; parity_err is tied to 0; the port is still present.

Decomposition:
- Package sram_pkg holds:
  - typedef enum logic {S_CLEAR, S_IDLE} sram_state_t.
  - function byte_parity(logic [7:0]) returning ^b.
  - localparam BYTE_W = 8.
- Sub-module sram_clear_seq contains the clear FSM, clr_cnt counter and busy generation. Its ports are clk, reset, busy, clr_we, clr_add.
- The top level muxes clear and user writes into the array.

Test Plan:
- Reset held 3 cycles then released, WIDTH = 32, DEPTH = 8: busy = 1 for exactly 8 cycles, then 0. Reads of addresses 0..7 each return 32'h0000_0000 with rd_valid one cycle after req.
- Write 32'hDEADBEEF to address 3 with be = 4'hF, then write 32'h11223344 to address 3 with be = 4'b0101: read of address 3 returns 32'hDE22BE44.
- Read address 5 on consecutive cycles after writing 32'hCAFEF00D there: rd_valid stays high both cycles and rd = 32'hCAFEF00D, each value appearing the cycle after its req.
- Assert reset at clear cycle 4, release, and drive a write request during busy: busy lasts a full DEPTH cycles again, the write is ignored, and address 0 reads 0.
- DEPTH = 6: write 32'h5 to address 7, then read address 7 -> rd = 0, rd_valid = 1. Address 0..5 contents are unchanged.
- With SRAM_PARITY_EN: write 32'h000000FF to address 2, then force-flip stored bit 0 of address 2 and read it -> parity_err = 1 with rd_valid = 1. A read of an unmodified address gives parity_err = 0.
